// File: rtl/val2_seq_shifter_pkg.sv
// +--------------------------------------------------------------------+
// | val2_seq_shifter_pkg : shared types and constants for val2 shifter |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package val2_seq_shifter_pkg;

  localparam int   REGISTER_LEN = 32;
  localparam logic ENABLE       = 1'b1;
  localparam logic DISABLE      = 1'b0;

  typedef enum logic [1:0] {
    LSL_SHIFT_STATE = 2'b00,
    LSR_SHIFT_STATE = 2'b01,
    ASR_SHIFT_STATE = 2'b10,
    ROR_SHIFT_STATE = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    SH_IDLE  = 2'b00,
    SH_SHIFT = 2'b01,
    SH_DONE  = 2'b10
  } state_t;

  // Register-specified amounts are clamped so every shift finishes within 33 single-bit moves.
  function automatic logic [5:0] reg_shift_amt(input shift_t t, input logic [7:0] rs);
    logic [5:0] amt;
    case (t)
      LSL_SHIFT_STATE, LSR_SHIFT_STATE: amt = (rs > 8'd33) ? 6'd33 : rs[5:0];
      ASR_SHIFT_STATE:                  amt = (rs > 8'd32) ? 6'd32 : rs[5:0];
      default: amt = (rs[4:0] == 5'd0 && rs != 8'd0) ? 6'd32 : {1'b0, rs[4:0]};
    endcase
    return amt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/val2_seq_shifter_shift_step.sv
// +--------------------------------------------------------------------+
// | shift_step : combinational single-step shifter, k = 0..32 bits     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module shift_step
  import val2_seq_shifter_pkg::*;
(
  input  logic [REGISTER_LEN-1:0] value,
  input  shift_t                  shift_type,
  input  logic [5:0]              k,
  input  logic                    carry_in,
  output logic [REGISTER_LEN-1:0] value_out,
  output logic                    carry_out
);

  logic        [32:0] w_lsl;
  logic        [32:0] w_lsr;
  logic signed [32:0] w_sext;
  logic signed [32:0] w_asr;
  logic        [63:0] w_ror;

  // A guard bit beside the word catches the last bit shifted out.
  assign w_lsl  = {1'b0, value} << k;
  assign w_lsr  = {value, 1'b0} >> k;
  assign w_sext = {value, 1'b0};
  assign w_asr  = w_sext >>> k;
  assign w_ror  = {value, value} >> k;

  always_comb begin
    value_out = value;
    carry_out = carry_in;
    case (shift_type)
      LSL_SHIFT_STATE: begin
        value_out = w_lsl[31:0];
        if (k != 6'd0) carry_out = w_lsl[32];
      end
      LSR_SHIFT_STATE: begin
        value_out = w_lsr[32:1];
        if (k != 6'd0) carry_out = w_lsr[0];
      end
      ASR_SHIFT_STATE: begin
        value_out = w_asr[32:1];
        if (k != 6'd0) carry_out = w_asr[0];
      end
      default: begin
        value_out = w_ror[31:0];
        if (k != 6'd0) carry_out = w_ror[31];
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/val2_seq_shifter.sv
// +--------------------------------------------------------------------+
// | val2_seq_shifter : multi-cycle ARM operand-2 generator, handshaked |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module val2_seq_shifter
  import val2_seq_shifter_pkg::*;
#(
  parameter int STEP      = 8,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REGISTER_LEN-1:0] Rm,
  input  logic [7:0]              Rs,
  input  logic [11:0]             shift_operand,
  input  logic                    immd,
  input  logic                    is_mem_command,
  input  logic                    carry_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [REGISTER_LEN-1:0] val2_out,
  output logic                    carry_out,
  output logic                    busy
);

  localparam logic [5:0] STEP_K = 6'(STEP);

  state_t                  r_state, w_state_next;
  logic [REGISTER_LEN-1:0] r_val;
  shift_t                  r_type;
  logic [5:0]              r_amt;
  logic                    r_carry;
  logic                    r_rrx;

  logic [REGISTER_LEN-1:0] w_dec_val;
  shift_t                  w_dec_type;
  logic [5:0]              w_dec_amt;
  logic                    w_dec_rrx;

  logic [5:0]              w_k, w_amt_next;
  logic [REGISTER_LEN-1:0] w_bs_val, w_step_val;
  logic                    w_bs_carry, w_step_carry;
  logic                    w_load, w_fast, w_finish;

  // Decode at acceptance: memory offset beats immediate beats register forms.
  always_comb begin
    w_dec_val  = Rm;
    w_dec_type = shift_t'(shift_operand[6:5]);
    w_dec_amt  = 6'd0;
    w_dec_rrx  = DISABLE;
    if (is_mem_command) begin
      w_dec_val  = {20'b0, shift_operand};
      w_dec_type = LSL_SHIFT_STATE;
    end else if (immd) begin
      w_dec_val  = {24'b0, shift_operand[7:0]};
      w_dec_type = ROR_SHIFT_STATE;
      w_dec_amt  = {1'b0, shift_operand[11:8], 1'b0};
    end else if (!shift_operand[4]) begin
      w_dec_amt = {1'b0, shift_operand[11:7]};
      if (shift_operand[11:7] == 5'd0) begin
        case (w_dec_type)
          LSR_SHIFT_STATE, ASR_SHIFT_STATE: w_dec_amt = 6'd32;
          ROR_SHIFT_STATE: begin
            w_dec_amt = 6'd1;
            w_dec_rrx = ENABLE;
          end
          default: w_dec_amt = 6'd0;
        endcase
      end
    end else begin
      w_dec_amt = reg_shift_amt(w_dec_type, Rs);
    end
  end

  assign w_k        = (r_amt > STEP_K) ? STEP_K : r_amt;
  assign w_amt_next = r_amt - w_k;

  shift_step u_shift_step (
    .value      (r_val),
    .shift_type (r_type),
    .k          (w_k),
    .carry_in   (r_carry),
    .value_out  (w_bs_val),
    .carry_out  (w_bs_carry)
  );

  // RRX rotates the old carry into bit 31 instead of bit 0.
  assign w_step_val   = r_rrx ? {r_carry, r_val[31:1]} : w_bs_val;
  assign w_step_carry = r_rrx ? r_val[0] : w_bs_carry;

  always_comb begin
    w_state_next = r_state;
    w_load       = DISABLE;
    w_fast       = DISABLE;
    w_finish     = DISABLE;
    case (r_state)
      SH_IDLE: begin
        if (in_valid) begin
          w_load = ENABLE;
          if (w_dec_amt == 6'd0 && FAST_ZERO) begin
            w_fast       = ENABLE;
            w_state_next = SH_DONE;
          end else begin
            w_state_next = SH_SHIFT;
          end
        end
      end
      SH_SHIFT: begin
        if (w_amt_next == 6'd0) begin
          w_finish     = ENABLE;
          w_state_next = SH_DONE;
        end
      end
      SH_DONE: if (out_ready) w_state_next = SH_IDLE;
      default: w_state_next = SH_IDLE;
    endcase
    if (flush) begin
      w_state_next = SH_IDLE;
      w_load       = DISABLE;
      w_fast       = DISABLE;
      w_finish     = DISABLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SH_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val     <= '0;
      r_type    <= LSL_SHIFT_STATE;
      r_amt     <= 6'd0;
      r_carry   <= 1'b0;
      r_rrx     <= 1'b0;
      val2_out  <= '0;
      carry_out <= 1'b0;
    end else if (w_load) begin
      r_val   <= w_dec_val;
      r_type  <= w_dec_type;
      r_amt   <= w_dec_amt;
      r_carry <= carry_in;
      r_rrx   <= w_dec_rrx;
      if (w_fast) begin
        val2_out  <= w_dec_val;
        carry_out <= carry_in;
      end
    end else if (r_state == SH_SHIFT && !flush) begin
      r_val   <= w_step_val;
      r_carry <= w_step_carry;
      r_amt   <= w_amt_next;
      if (w_finish) begin
        val2_out  <= w_step_val;
        carry_out <= w_step_carry;
      end
    end
  end

  assign in_ready  = (r_state == SH_IDLE);
  assign out_valid = (r_state == SH_DONE);
  assign busy      = (r_state != SH_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_val2_seq_shifter.sv
// +--------------------------------------------------------------------+
// | tb_val2_seq_shifter : table-driven scoreboard bench, STEP=8        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_val2_seq_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] Rm = '0;
  logic [7:0]  Rs = '0;
  logic [11:0] shift_operand = '0;
  logic        immd = 1'b0;
  logic        is_mem_command = 1'b0;
  logic        carry_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] val2_out;
  logic        carry_out;
  logic        busy;

  val2_seq_shifter #(.STEP(8), .FAST_ZERO(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .Rm             (Rm),
    .Rs             (Rs),
    .shift_operand  (shift_operand),
    .immd           (immd),
    .is_mem_command (is_mem_command),
    .carry_in       (carry_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .val2_out       (val2_out),
    .carry_out      (carry_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rm;
    logic [7:0]  rs;
    logic [11:0] so;
    logic        im;
    logic        mem;
    logic        cin;
    logic [31:0] val;
    logic        c;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] val;
    logic        c;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[15];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one request at a negedge; returns at the negedge after the accept edge.
  task automatic drive(input vec_t v, input bit push);
    @(negedge clk);
    Rm = v.rm; Rs = v.rs; shift_operand = v.so;
    immd = v.im; is_mem_command = v.mem; carry_in = v.cin;
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    if (push) sb.push_back('{v.val, v.c, v.lat});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input int stall);
    int   lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty: got result %h expected none", val2_out);
      return;
    end
    e = sb.pop_front();
    if (!out_valid) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: got no out_valid expected latency %0d", e.lat);
      return;
    end
    chk("val2_out", val2_out, e.val);
    chk("carry_out", carry_out, e.c);
    chk("latency", lat, e.lat);
    for (int i = 0; i < stall; i++) begin
      Rm = 32'h5555_AAAA; is_mem_command = 1'b1; shift_operand = 12'h123; in_valid = 1'b1;
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", val2_out, e.val);
      chk("stall_carry", carry_out, e.c);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    last_val = e.val;
  endtask

  initial begin
    vec_t asr32;
    //        rm            rs     so      im    mem   cin   val           c     lat
    vecs[0]  = '{32'h0,        8'd0,  12'h4FF, 1'b1, 1'b0, 1'b0, 32'hFF000000, 1'b1, 1};
    vecs[1]  = '{32'h80000001, 8'd0,  12'h020, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 4};
    vecs[2]  = '{32'h00000003, 8'd0,  12'h060, 1'b0, 1'b0, 1'b1, 32'h80000001, 1'b1, 1};
    vecs[3]  = '{32'hFFFFFFFF, 8'd40, 12'h010, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 5};
    vecs[4]  = '{32'h12345678, 8'd64, 12'h070, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 4};
    vecs[5]  = '{32'h0,        8'd0,  12'hABC, 1'b0, 1'b1, 1'b1, 32'h00000ABC, 1'b1, 0};
    vecs[6]  = '{32'hF000000F, 8'd0,  12'h200, 1'b0, 1'b0, 1'b0, 32'h000000F0, 1'b1, 1};
    vecs[7]  = '{32'h80000000, 8'd100,12'h050, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 4};
    vecs[8]  = '{32'h12345678, 8'd0,  12'h660, 1'b0, 1'b0, 1'b1, 32'h67812345, 1'b0, 2};
    vecs[9]  = '{32'hDEADBEEF, 8'd0,  12'h030, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 0};
    vecs[10] = '{32'h80000000, 8'd33, 12'h030, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 5};
    vecs[11] = '{32'h80000000, 8'd32, 12'h030, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 4};
    vecs[12] = '{32'h80000010, 8'd0,  12'h1C0, 1'b0, 1'b0, 1'b1, 32'hF0000002, 1'b0, 1};
    vecs[13] = '{32'h0,        8'd0,  12'h0AB, 1'b1, 1'b0, 1'b1, 32'h000000AB, 1'b1, 0};
    vecs[14] = '{32'h0000000F, 8'h24, 12'h070, 1'b0, 1'b0, 1'b0, 32'hF0000000, 1'b1, 1};
    asr32    = '{32'h80000000, 8'd0,  12'h040, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 4};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_val2", val2_out, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i], 1'b1);
      collect(0);
    end

    // Zero-amount result held through a 5-cycle stall with a competing request
    drive(vecs[5], 1'b1);
    collect(5);

    // Flush in SHIFT beats simultaneous in_valid and out_ready
    drive(asr32, 1'b0);
    chk("flush_busy_before", busy, 1);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_busy", busy, 0);
    chk("flush_val2_kept", val2_out, last_val);
    repeat (6) @(negedge clk);
    chk("flush_no_late_valid", out_valid, 0);
    drive(asr32, 1'b1);
    collect(0);

    // Asynchronous reset mid-shift
    drive(vecs[3], 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_val2", val2_out, 0);
    chk("arst_carry", carry_out, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(vecs[8], 1'b1);
    collect(0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
